// File: rtl/wb_commit.sv
// Write-back/commit stage: latches the MEM->WB bus, writes the register file, owns HI/LO and
// CP0 Status/Cause/EPC, and commits syscall/overflow exceptions and eret with a fetch redirect.
module wb_commit #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         MEM_over,
  input  logic [118:0] MEM_WB_bus,
  output logic         WB_allow_in,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         cancel,
  output logic         exc_valid,
  output logic [31:0]  exc_pc,
  output logic [31:0]  WB_pc,
  output logic [31:0]  cp0_status,
  output logic [31:0]  cp0_cause,
  output logic [31:0]  cp0_epc
);

  localparam logic [7:0] AddrStatus = 8'h60;
  localparam logic [7:0] AddrCause  = 8'h68;
  localparam logic [7:0] AddrEpc    = 8'h70;
  localparam logic [4:0] ExcOv      = 5'd12;
  localparam logic [4:0] ExcSys     = 5'd8;

  logic         wb_valid_q, wb_valid_d;
  logic [118:0] bus_q, bus_d;
  logic [31:0]  hi_q, hi_d;
  logic [31:0]  lo_q, lo_d;
  logic [31:0]  status_q, status_d;
  logic [31:0]  cause_q, cause_d;
  logic [31:0]  epc_q, epc_d;

  // Bus field decode
  logic        bus_rf_wen;
  logic [4:0]  bus_wdest;
  logic [31:0] mem_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;
  logic        op_mfhi;
  logic        op_mflo;
  logic        op_mtc0;
  logic        op_mfc0;
  logic [7:0]  cp0r_addr;
  logic        op_syscall;
  logic        op_eret;
  logic        op_overflow;
  logic [31:0] bus_pc;

  assign bus_rf_wen  = bus_q[118];
  assign bus_wdest   = bus_q[117:113];
  assign mem_result  = bus_q[112:81];
  assign lo_result   = bus_q[80:49];
  assign hi_write    = bus_q[48];
  assign lo_write    = bus_q[47];
  assign op_mfhi     = bus_q[46];
  assign op_mflo     = bus_q[45];
  assign op_mtc0     = bus_q[44];
  assign op_mfc0     = bus_q[43];
  assign cp0r_addr   = bus_q[42:35];
  assign op_syscall  = bus_q[34];
  assign op_eret     = bus_q[33];
  assign op_overflow = bus_q[32];
  assign bus_pc      = bus_q[31:0];

  logic exc_commit;
  logic eret_commit;
  logic mtc0_commit;

  // Exception outranks eret, which outranks mtc0.
  assign exc_commit  = wb_valid_q & (op_overflow | op_syscall);
  assign eret_commit = wb_valid_q & op_eret & ~(op_overflow | op_syscall);
  assign mtc0_commit = wb_valid_q & op_mtc0 & ~(op_overflow | op_syscall | op_eret);

  assign WB_over     = wb_valid_q;
  assign WB_allow_in = ~wb_valid_q | WB_over;

  assign cancel    = exc_commit | eret_commit;
  assign exc_valid = cancel;

  always_comb begin
    exc_pc = 32'h0;
    if (exc_commit) begin
      exc_pc = EXC_ENTRY;
    end else if (eret_commit) begin
      exc_pc = epc_q;
    end
  end

  logic [31:0] cp0_rdata;

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0r_addr)
      AddrStatus: cp0_rdata = status_q;
      AddrCause:  cp0_rdata = cause_q;
      AddrEpc:    cp0_rdata = epc_q;
      default:    cp0_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rf_wdata = mem_result;
    if (op_mfhi) begin
      rf_wdata = hi_q;
    end else if (op_mflo) begin
      rf_wdata = lo_q;
    end else if (op_mfc0) begin
      rf_wdata = cp0_rdata;
    end
  end

  assign rf_wen     = wb_valid_q & bus_rf_wen & ~op_overflow & ~op_syscall;
  assign rf_wdest   = bus_wdest;
  assign WB_wdest   = rf_wdest & {5{wb_valid_q}};
  assign WB_pc      = bus_pc;
  assign cp0_status = status_q;
  assign cp0_cause  = cause_q;
  assign cp0_epc    = epc_q;

  always_comb begin
    wb_valid_d = wb_valid_q;
    bus_d      = bus_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;

    // An instruction arriving while WB cancels is dropped.
    if (WB_allow_in) begin
      wb_valid_d = MEM_over & ~cancel;
    end
    if (MEM_over & WB_allow_in) begin
      bus_d = MEM_WB_bus;
    end

    if (wb_valid_q & ~op_overflow) begin
      if (hi_write) hi_d = mem_result;
      if (lo_write) lo_d = lo_result;
    end

    if (exc_commit) begin
      epc_d       = bus_pc;
      status_d[1] = 1'b1;
      cause_d[6:2] = op_overflow ? ExcOv : ExcSys;
    end else if (eret_commit) begin
      status_d[1] = 1'b0;
    end else if (mtc0_commit) begin
      case (cp0r_addr)
        AddrStatus: status_d = {16'h0, mem_result[15:8], 6'h0, mem_result[1:0]};
        AddrCause:  cause_d  = {cause_q[31:10], mem_result[9:8], cause_q[7:0]};
        AddrEpc:    epc_d    = mem_result;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      bus_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      status_q   <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      bus_q      <= bus_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: a table of single-instruction vectors plus hand-written
// exception, eret and reset sequences.
module tb_wb_commit;

  logic         clk = 1'b0;
  logic         resetn;
  logic         MEM_over;
  logic [118:0] MEM_WB_bus;
  logic         WB_allow_in, WB_over, rf_wen, cancel, exc_valid;
  logic [4:0]   WB_wdest, rf_wdest;
  logic [31:0]  rf_wdata, exc_pc, WB_pc, cp0_status, cp0_cause, cp0_epc;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  wb_commit dut (
    .clk        (clk),
    .resetn     (resetn),
    .MEM_over   (MEM_over),
    .MEM_WB_bus (MEM_WB_bus),
    .WB_allow_in(WB_allow_in),
    .WB_over    (WB_over),
    .WB_wdest   (WB_wdest),
    .rf_wen     (rf_wen),
    .rf_wdest   (rf_wdest),
    .rf_wdata   (rf_wdata),
    .cancel     (cancel),
    .exc_valid  (exc_valid),
    .exc_pc     (exc_pc),
    .WB_pc      (WB_pc),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .cp0_epc    (cp0_epc)
  );

  function automatic logic [118:0] mk(input logic wen, input logic [4:0] wd,
                                      input logic [31:0] mr, input logic [31:0] lr,
                                      input logic hw, input logic lw, input logic mfhi,
                                      input logic mflo, input logic mtc0, input logic mfc0,
                                      input logic [7:0] addr, input logic sys,
                                      input logic eret, input logic ov,
                                      input logic [31:0] pc);
    return {wen, wd, mr, lr, hw, lw, mfhi, mflo, mtc0, mfc0, addr, sys, eret, ov, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input logic mo, input logic [118:0] b);
    @(negedge clk);
    MEM_over   = mo;
    MEM_WB_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn     = 1'b0;
    MEM_over   = 1'b1;
    MEM_WB_bus = mk(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_over", {31'h0, WB_over}, 0);
    chk("rst_rf_wen", {31'h0, rf_wen}, 0);
    chk("rst_wb_wdest", {27'h0, WB_wdest}, 0);
    chk("rst_cancel", {31'h0, cancel}, 0);
    chk("rst_status", cp0_status, 0);
    chk("rst_cause", cp0_cause, 0);
    chk("rst_epc", cp0_epc, 0);
    @(negedge clk);
    resetn   = 1'b1;
    MEM_over = 1'b0;
  endtask

  typedef struct {
    logic [118:0] bus;
    logic         wen;
    logic [4:0]   wdest;
    logic [31:0]  wdata;
  } vec_t;

  vec_t tv [12];

  initial begin
    resetn     = 1'b0;
    MEM_over   = 1'b0;
    MEM_WB_bus = '0;

    //          wen wd     mem_result     lo_result     hw lw hi lo mt mf addr  sy er ov pc
    tv[0]  = '{mk(1, 5'd5,  32'h1234_5678, 0,            0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 32'h04),
               1, 5'd5,  32'h1234_5678};
    tv[1]  = '{mk(0, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 32'h08),
               0, 5'd0,  32'hFFFF_FFFF};
    tv[2]  = '{mk(1, 5'd8,  32'h0,         0,            0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 32'h0C),
               1, 5'd8,  32'hFFFF_FFFF};
    tv[3]  = '{mk(1, 5'd9,  32'h0,         0,            0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 32'h10),
               1, 5'd9,  32'hFFFF_FFFE};
    tv[4]  = '{mk(0, 5'd0,  32'hFFFF_FFFF, 0,            0, 0, 0, 0, 1, 0, 8'h60, 0, 0, 0, 32'h14),
               0, 5'd0,  32'hFFFF_FFFF};
    tv[5]  = '{mk(1, 5'd10, 32'h0,         0,            0, 0, 0, 0, 0, 1, 8'h60, 0, 0, 0, 32'h18),
               1, 5'd10, 32'h0000_FF03};
    tv[6]  = '{mk(0, 5'd0,  32'hFFFF_FFFF, 0,            0, 0, 0, 0, 1, 0, 8'h68, 0, 0, 0, 32'h1C),
               0, 5'd0,  32'hFFFF_FFFF};
    tv[7]  = '{mk(1, 5'd11, 32'h0,         0,            0, 0, 0, 0, 0, 1, 8'h68, 0, 0, 0, 32'h20),
               1, 5'd11, 32'h0000_0300};
    tv[8]  = '{mk(0, 5'd0,  32'h0000_1234, 0,            0, 0, 0, 0, 1, 0, 8'h70, 0, 0, 0, 32'h24),
               0, 5'd0,  32'h0000_1234};
    tv[9]  = '{mk(1, 5'd12, 32'h0,         0,            0, 0, 0, 0, 0, 1, 8'h70, 0, 0, 0, 32'h28),
               1, 5'd12, 32'h0000_1234};
    tv[10] = '{mk(1, 5'd13, 32'hDEAD_BEEF, 0,            0, 0, 0, 0, 0, 1, 8'h08, 0, 0, 0, 32'h2C),
               1, 5'd13, 32'h0};
    tv[11] = '{mk(1, 5'd14, 32'h0,         0,            0, 0, 1, 1, 0, 1, 8'h60, 0, 0, 0, 32'h30),
               1, 5'd14, 32'hFFFF_FFFF};

    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(1'b1, tv[i].bus);
      chk($sformatf("v%0d_rf_wen", i), {31'h0, rf_wen}, {31'h0, tv[i].wen});
      chk($sformatf("v%0d_rf_wdest", i), {27'h0, rf_wdest}, {27'h0, tv[i].wdest});
      chk($sformatf("v%0d_wb_wdest", i), {27'h0, WB_wdest}, {27'h0, tv[i].wdest});
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tv[i].wdata);
      chk($sformatf("v%0d_cancel", i), {31'h0, cancel}, 0);
    end

    // Overflow: write suppressed, redirect, and the follower is dropped.
    do_reset();
    step(1'b1, mk(1, 5'd3, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100));
    chk("ov_rf_wen", {31'h0, rf_wen}, 0);
    chk("ov_cancel", {31'h0, cancel}, 1);
    chk("ov_exc_valid", {31'h0, exc_valid}, 1);
    chk("ov_exc_pc", exc_pc, 32'hBFC0_0380);
    step(1'b1, mk(1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104));
    chk("ov_drop_valid", {31'h0, WB_over}, 0);
    chk("ov_drop_rf_wen", {31'h0, rf_wen}, 0);
    chk("ov_cancel_pulse", {31'h0, cancel}, 0);
    chk("ov_epc", cp0_epc, 32'h100);
    chk("ov_cause", cp0_cause, 32'h30);
    chk("ov_status", cp0_status, 32'h2);

    // Syscall then eret (eret also carries an mtc0 EPC that must be ignored).
    do_reset();
    step(1'b1, mk(1, 5'd4, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h200));
    chk("sys_cancel", {31'h0, cancel}, 1);
    chk("sys_rf_wen", {31'h0, rf_wen}, 0);
    step(1'b0, '0);
    chk("sys_cause", cp0_cause, 32'h20);
    chk("sys_epc", cp0_epc, 32'h200);
    chk("sys_status", cp0_status, 32'h2);
    step(1'b1, mk(0, 5'd0, 32'h999, 0, 0, 0, 0, 0, 1, 0, 8'h70, 0, 1, 0, 32'h300));
    chk("eret_cancel", {31'h0, cancel}, 1);
    chk("eret_exc_valid", {31'h0, exc_valid}, 1);
    chk("eret_exc_pc", exc_pc, 32'h200);
    step(1'b0, '0);
    chk("eret_status", cp0_status, 32'h0);
    chk("eret_epc_kept", cp0_epc, 32'h200);
    chk("eret_cancel_pulse", {31'h0, cancel}, 0);

    // Reset while a syscall is pending commit.
    step(1'b1, mk(1, 5'd4, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h400));
    chk("mid_cancel_pre", {31'h0, cancel}, 1);
    @(negedge clk);
    resetn   = 1'b0;
    MEM_over = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_cancel", {31'h0, cancel}, 0);
    chk("mid_epc", cp0_epc, 32'h0);
    chk("mid_wb_pc", WB_pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
